// File: rtl/reg_rd_if.sv
// reg_rd_if: the decode-to-execute bus of the operand-read stage.
//
// Carries the decoded instruction into the stage (IN_*) and the issued
// operands out of it (OUT_*, OP_*). Every signal keeps its stage port name.
//
// Handshake: each side transfers only on a cycle where its VALID and READY
// are both high at the rising edge. VALID does not depend on READY. The
// producer holds VALID and payload stable until that transfer happens.
// IN_READY is combinational in this stage and may drop for hazards or FLUSH.
//
// Modports
//   master : decode/execute environment (drives instruction, consumes operands)
//   slave  : the reg_rd stage
interface reg_rd_if #(
    parameter int DATA_W = 16
);
    logic              IN_VALID;
    logic              IN_READY;
    logic              USE_A;
    logic              USE_B;
    logic [2:0]        N_REG_A;
    logic [2:0]        N_REG_B;
    logic              DST_WEN;
    logic [2:0]        N_REG_DST;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [DATA_W-1:0] OP_A;
    logic [DATA_W-1:0] OP_B;
    logic              OUT_DST_WEN;
    logic [2:0]        OUT_N_DST;

    modport master (
        output IN_VALID, USE_A, USE_B, N_REG_A, N_REG_B, DST_WEN, N_REG_DST, OUT_READY,
        input  IN_READY, OUT_VALID, OP_A, OP_B, OUT_DST_WEN, OUT_N_DST
    );

    modport slave (
        input  IN_VALID, USE_A, USE_B, N_REG_A, N_REG_B, DST_WEN, N_REG_DST, OUT_READY,
        output IN_READY, OUT_VALID, OP_A, OP_B, OUT_DST_WEN, OUT_N_DST
    );
endinterface

// File: rtl/reg_rd.sv
// reg_rd: operand-read stage on the read side of the 8 x DATA_W register file.
//
// Accepts a decoded instruction, reads its two source operands (forwarding the
// same-cycle write-back value when BYPASS_EN=1), tracks outstanding writes in
// a pending scoreboard so a stale operand is never issued, and presents the
// result to execute through a one-entry output register.
//
// Ports
//   CLK_RD        stage clock, rising edge
//   RESET         asynchronous, active-high; clears all state
//   REG_0..REG_7  register file contents (value before this cycle's write)
//   WB_REG_WEN    write-back strobe
//   WB_N_REG      write-back register index
//   WB_REG_IN     write-back data
//   FLUSH         synchronous discard of the held instruction
//   PEND          scoreboard, bit i = write to REG_i outstanding
//   bus           reg_rd_if.slave: instruction in, operands out
module reg_rd #(
    parameter int DATA_W    = 16,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic              CLK_RD,
    input  logic              RESET,
    input  logic [DATA_W-1:0] REG_0,
    input  logic [DATA_W-1:0] REG_1,
    input  logic [DATA_W-1:0] REG_2,
    input  logic [DATA_W-1:0] REG_3,
    input  logic [DATA_W-1:0] REG_4,
    input  logic [DATA_W-1:0] REG_5,
    input  logic [DATA_W-1:0] REG_6,
    input  logic [DATA_W-1:0] REG_7,
    input  logic              WB_REG_WEN,
    input  logic [2:0]        WB_N_REG,
    input  logic [DATA_W-1:0] WB_REG_IN,
    input  logic              FLUSH,
    output logic [7:0]        PEND,
    reg_rd_if.slave           bus
);
    logic [DATA_W-1:0] regs [8];

    logic              out_valid_q,   out_valid_d;
    logic [DATA_W-1:0] op_a_q,        op_a_d;
    logic [DATA_W-1:0] op_b_q,        op_b_d;
    logic              out_dst_wen_q, out_dst_wen_d;
    logic [2:0]        out_n_dst_q,   out_n_dst_d;
    logic [7:0]        pend_q,        pend_d;

    logic match_a, match_b, match_dst;
    logic hazard, in_ready, accept;

    assign regs[0] = REG_0;
    assign regs[1] = REG_1;
    assign regs[2] = REG_2;
    assign regs[3] = REG_3;
    assign regs[4] = REG_4;
    assign regs[5] = REG_5;
    assign regs[6] = REG_6;
    assign regs[7] = REG_7;

    always_comb begin
        match_a   = WB_REG_WEN && (WB_N_REG == bus.N_REG_A);
        match_b   = WB_REG_WEN && (WB_N_REG == bus.N_REG_B);
        match_dst = WB_REG_WEN && (WB_N_REG == bus.N_REG_DST);

        // A pending source is only safe if this cycle's write-back delivers it.
        // A pending destination is safe only if its write retires this cycle,
        // keeping at most one outstanding write per register.
        hazard = (bus.USE_A   && pend_q[bus.N_REG_A]   && !(BYPASS_EN && match_a))
              || (bus.USE_B   && pend_q[bus.N_REG_B]   && !(BYPASS_EN && match_b))
              || (bus.DST_WEN && pend_q[bus.N_REG_DST] && !match_dst);

        in_ready = !FLUSH && !hazard && (!out_valid_q || bus.OUT_READY);
        accept   = bus.IN_VALID && in_ready;
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        out_dst_wen_d = out_dst_wen_q;
        out_n_dst_d   = out_n_dst_q;
        pend_d        = pend_q;

        if (FLUSH) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d   = 1'b1;
            op_a_d        = (BYPASS_EN && match_a) ? WB_REG_IN : regs[bus.N_REG_A];
            op_b_d        = (BYPASS_EN && match_b) ? WB_REG_IN : regs[bus.N_REG_B];
            out_dst_wen_d = bus.DST_WEN;
            out_n_dst_d   = bus.N_REG_DST;
        end else if (bus.OUT_READY) begin
            out_valid_d = 1'b0;
        end

        // Clears first, set last, so a new reservation wins over a same-cycle clear.
        if (WB_REG_WEN) begin
            pend_d[WB_N_REG] = 1'b0;
        end
        if (FLUSH && out_valid_q && out_dst_wen_q) begin
            pend_d[out_n_dst_q] = 1'b0;
        end
        if (accept && bus.DST_WEN) begin
            pend_d[bus.N_REG_DST] = 1'b1;
        end
    end

    always_ff @(posedge CLK_RD or posedge RESET) begin
        if (RESET) begin
            out_valid_q   <= 1'b0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            out_dst_wen_q <= 1'b0;
            out_n_dst_q   <= 3'd0;
            pend_q        <= 8'h00;
        end else begin
            out_valid_q   <= out_valid_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            out_dst_wen_q <= out_dst_wen_d;
            out_n_dst_q   <= out_n_dst_d;
            pend_q        <= pend_d;
        end
    end

    assign bus.IN_READY    = in_ready;
    assign bus.OUT_VALID   = out_valid_q;
    assign bus.OP_A        = op_a_q;
    assign bus.OP_B        = op_b_q;
    assign bus.OUT_DST_WEN = out_dst_wen_q;
    assign bus.OUT_N_DST   = out_n_dst_q;
    assign PEND            = pend_q;
endmodule

// File: tb/tb_reg_rd.sv
// tb_reg_rd: directed bench for the reg_rd operand-read stage.
module tb_reg_rd;
    localparam int DATA_W = 16;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] reg_v [8];
    logic              wb_reg_wen;
    logic [2:0]        wb_n_reg;
    logic [DATA_W-1:0] wb_reg_in;
    logic              flush;
    logic [7:0]        pend;

    int checks;
    int failures;

    reg_rd_if #(.DATA_W(DATA_W)) bus ();

    reg_rd #(.DATA_W(DATA_W), .BYPASS_EN(1'b1)) dut (
        .CLK_RD     (clk),
        .RESET      (rst),
        .REG_0      (reg_v[0]),
        .REG_1      (reg_v[1]),
        .REG_2      (reg_v[2]),
        .REG_3      (reg_v[3]),
        .REG_4      (reg_v[4]),
        .REG_5      (reg_v[5]),
        .REG_6      (reg_v[6]),
        .REG_7      (reg_v[7]),
        .WB_REG_WEN (wb_reg_wen),
        .WB_N_REG   (wb_n_reg),
        .WB_REG_IN  (wb_reg_in),
        .FLUSH      (flush),
        .PEND       (pend),
        .bus        (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_instr(input logic v, input logic ua, input logic [2:0] a,
                               input logic ub, input logic [2:0] b,
                               input logic dw, input logic [2:0] d);
        bus.IN_VALID  = v;
        bus.USE_A     = ua;
        bus.N_REG_A   = a;
        bus.USE_B     = ub;
        bus.N_REG_B   = b;
        bus.DST_WEN   = dw;
        bus.N_REG_DST = d;
    endtask

    task automatic drive_wb(input logic en, input logic [2:0] n, input logic [DATA_W-1:0] d);
        wb_reg_wen = en;
        wb_n_reg   = n;
        wb_reg_in  = d;
    endtask

    task automatic check_ready(input string tag, input logic exp);
        #1;
        check(tag, {31'd0, bus.IN_READY}, {31'd0, exp});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        flush    = 1'b0;
        reg_v[0] = 16'h0000;
        reg_v[1] = 16'h1111;
        reg_v[2] = 16'h2222;
        reg_v[3] = 16'h1234;
        reg_v[4] = 16'h4444;
        reg_v[5] = 16'h0F0F;
        reg_v[6] = 16'h6666;
        reg_v[7] = 16'h7777;
        drive_wb(1'b0, 3'd0, 16'h0000);
        drive_instr(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
        bus.OUT_READY = 1'b1;

        // reset state
        #2;
        check("rst_out_valid", {31'd0, bus.OUT_VALID}, 32'd0);
        check("rst_op_a", {16'd0, bus.OP_A}, 32'd0);
        check("rst_op_b", {16'd0, bus.OP_B}, 32'd0);
        check("rst_pend", {24'd0, pend}, 32'd0);
        step();
        step();
        #2;
        rst = 1'b0;
        step();

        // 1: plain read of REG_3 / REG_5
        drive_instr(1'b1, 1'b1, 3'd3, 1'b1, 3'd5, 1'b0, 3'd0);
        check_ready("t1_in_ready", 1'b1);
        step();
        check("t1_out_valid", {31'd0, bus.OUT_VALID}, 32'd1);
        check("t1_op_a", {16'd0, bus.OP_A}, 32'h1234);
        check("t1_op_b", {16'd0, bus.OP_B}, 32'h0F0F);
        check("t1_pend", {24'd0, pend}, 32'h00);

        // 2: reserve REG_2, RAW stall, release through bypass
        drive_instr(1'b1, 1'b1, 3'd3, 1'b1, 3'd5, 1'b1, 3'd2);
        check_ready("t2_dst_ready", 1'b1);
        step();
        check("t2_pend_set", {24'd0, pend}, 32'h04);
        check("t2_dst_wen", {31'd0, bus.OUT_DST_WEN}, 32'd1);
        drive_instr(1'b1, 1'b1, 3'd2, 1'b1, 3'd5, 1'b0, 3'd0);
        check_ready("t2_raw_stall", 1'b0);
        step();
        check("t2_drained", {31'd0, bus.OUT_VALID}, 32'd0);
        check_ready("t2_raw_stall2", 1'b0);
        drive_wb(1'b1, 3'd2, 16'hBEEF);
        check_ready("t2_bypass_ready", 1'b1);
        step();
        drive_wb(1'b0, 3'd0, 16'h0000);
        check("t2_bypass_op_a", {16'd0, bus.OP_A}, 32'hBEEF);
        check("t2_op_b", {16'd0, bus.OP_B}, 32'h0F0F);
        check("t2_pend_clr", {24'd0, pend}, 32'h00);
        check("t2_out_valid", {31'd0, bus.OUT_VALID}, 32'd1);

        // 3: back-pressure holds the output register, then full throughput
        bus.OUT_READY = 1'b0;
        drive_instr(1'b1, 1'b1, 3'd4, 1'b1, 3'd1, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            check_ready("t3_bp_ready", 1'b0);
            step();
            check("t3_hold_valid", {31'd0, bus.OUT_VALID}, 32'd1);
            check("t3_hold_op_a", {16'd0, bus.OP_A}, 32'hBEEF);
            check("t3_hold_op_b", {16'd0, bus.OP_B}, 32'h0F0F);
        end
        bus.OUT_READY = 1'b1;
        check_ready("t3_release_ready", 1'b1);
        step();
        check("t3_b2b1_op_a", {16'd0, bus.OP_A}, 32'h4444);
        check("t3_b2b1_op_b", {16'd0, bus.OP_B}, 32'h1111);
        drive_instr(1'b1, 1'b1, 3'd6, 1'b1, 3'd7, 1'b0, 3'd0);
        check_ready("t3_b2b2_ready", 1'b1);
        step();
        check("t3_b2b2_op_a", {16'd0, bus.OP_A}, 32'h6666);
        check("t3_b2b2_op_b", {16'd0, bus.OP_B}, 32'h7777);
        check("t3_b2b2_valid", {31'd0, bus.OUT_VALID}, 32'd1);

        // 4: WAW on REG_4, same-cycle set and clear
        drive_instr(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd4);
        step();
        check("t4_pend_set", {24'd0, pend}, 32'h10);
        drive_wb(1'b1, 3'd4, 16'h5555);
        check_ready("t4_waw_wb_ready", 1'b1);
        step();
        drive_wb(1'b0, 3'd0, 16'h0000);
        check("t4_set_wins", {24'd0, pend}, 32'h10);
        check("t4_out_n_dst", {29'd0, bus.OUT_N_DST}, 32'd4);
        check_ready("t4_waw_stall", 1'b0);
        step();
        check("t4_waw_no_accept", {31'd0, bus.OUT_VALID}, 32'd0);

        // 5: flush a held instruction that reserved REG_6
        drive_instr(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
        drive_wb(1'b1, 3'd4, 16'h5555);
        step();
        drive_wb(1'b0, 3'd0, 16'h0000);
        check("t5_pend_clear4", {24'd0, pend}, 32'h00);
        bus.OUT_READY = 1'b0;
        drive_instr(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd6);
        check_ready("t5_dst6_ready", 1'b1);
        step();
        check("t5_pend6", {24'd0, pend}, 32'h40);
        check("t5_held_valid", {31'd0, bus.OUT_VALID}, 32'd1);
        drive_instr(1'b1, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 3'd0);
        flush = 1'b1;
        check_ready("t5_flush_ready", 1'b0);
        step();
        flush = 1'b0;
        check("t5_flush_valid", {31'd0, bus.OUT_VALID}, 32'd0);
        check("t5_flush_pend", {24'd0, pend}, 32'h00);

        // 6: asynchronous reset in the middle of a stall
        drive_instr(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd1);
        step();
        check("t6_pend1", {24'd0, pend}, 32'h02);
        drive_instr(1'b1, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 3'd0);
        check_ready("t6_stall", 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("t6_arst_valid", {31'd0, bus.OUT_VALID}, 32'd0);
        check("t6_arst_op_a", {16'd0, bus.OP_A}, 32'd0);
        check("t6_arst_op_b", {16'd0, bus.OP_B}, 32'd0);
        check("t6_arst_dst_wen", {31'd0, bus.OUT_DST_WEN}, 32'd0);
        check("t6_arst_n_dst", {29'd0, bus.OUT_N_DST}, 32'd0);
        check("t6_arst_pend", {24'd0, pend}, 32'd0);
        step();
        #2;
        rst = 1'b0;
        bus.OUT_READY = 1'b1;
        drive_instr(1'b1, 1'b1, 3'd3, 1'b1, 3'd5, 1'b0, 3'd0);
        check_ready("t6_rel_ready", 1'b1);
        step();
        drive_instr(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
        check("t6_rel_valid", {31'd0, bus.OUT_VALID}, 32'd1);
        check("t6_rel_op_a", {16'd0, bus.OP_A}, 32'h1234);
        check("t6_rel_op_b", {16'd0, bus.OP_B}, 32'h0F0F);
        check("t6_rel_pend", {24'd0, pend}, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
